filter_relay_driver: RTL and testbench
======================================

Name: filter_relay_driver

Overview:
- Sits directly downstream of the band filter selector and consumes its 7-bit one-hot/combined filter word.
- Qualifies each change, defers it while transmitting, and shifts the word serially into the external relay-driver shift register (74HC595-class) with break-before-make sequencing.
- Reports the filter set currently applied and asserts a TX inhibit while relays are open or settling.

Parameters:
- CLK_DIV, 4, clock cycles per half-period of sr_clk (>=1)
- STABLE_CYCLES, 1024, cycles selected_filter must be unchanged before a switch starts (>=1)
- BREAK_CYCLES, 2048, dwell with all relays released before make
- SETTLE_CYCLES, 4096, dwell after make before tx_inhibit drops

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- selected_filter  in  7  requested relay pattern from the filter selector
- ptt  in  1  transmit active; no switch may start while high
- sr_clk  out  1  shift clock to relay driver
- sr_data  out  1  serial data, MSB first
- sr_latch  out  1  storage-register latch pulse
- filter_active  out  7  pattern last latched into the relays
- busy  out  1  high from QUALIFY exit until WAIT_SETTLE ends
- tx_inhibit  out  1  high from BREAK shift start through end of settle

Behaviour:
- Interface: one clock (clock); reset_n is asynchronous, active-low.
- Reset values: sr_clk=0, sr_data=0, sr_latch=0, filter_active=0, busy=0, tx_inhibit=0, state=IDLE, all counters 0.
- Reset mid-operation aborts immediately with no completion. Because filter_active returns to 0, any nonzero request re-qualifies after release.
- Frame format: 8 bits, {1'b0, pattern[6:0]}, MSB first.
  - sr_data is set while sr_clk is low. sr_clk is high for CLK_DIV cycles, then low for CLK_DIV cycles, per bit.
  - After bit 0, sr_latch is high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - Frame length is 18*CLK_DIV cycles.
- States:
  - IDLE: if selected_filter != filter_active, go to QUALIFY and load target=selected_filter.
  - QUALIFY: counts cycles.
    - If selected_filter != target, reload target and restart the count.
    - If selected_filter == filter_active, return to IDLE.
    - When the count reaches STABLE_CYCLES and ptt=0, go to SHIFT_BREAK.
    - While ptt=1, hold at the terminal count (deferred) and keep tracking target.
  - SHIFT_BREAK: shift the all-zero frame; tx_inhibit=1, busy=1. Then go to WAIT_BREAK.
  - WAIT_BREAK: wait BREAK_CYCLES, then go to SHIFT_MAKE.
  - SHIFT_MAKE: shift the target frame. filter_active<=target on the cycle sr_latch rises. Then go to WAIT_SETTLE.
  - WAIT_SETTLE: wait SETTLE_CYCLES, then return to IDLE with busy=0 and tx_inhibit=0 on the same edge.
- Once SHIFT_BREAK is entered, the sequence always completes.
  - ptt rising mid-sequence does not abort it; tx_inhibit stays asserted so the radio holds TX.
  - selected_filter changes mid-sequence are ignored. Back in IDLE the mismatch is detected and re-qualified (full STABLE_CYCLES).
- ptt and selected_filter are used as-is: they are synchronous to clock, and selected_filter is registered upstream.
- Counters are sized by $clog2 of the largest parameter + 1 and never wrap. Terminal-count compares are ==.
- An all-zero selected_filter is handled as a normal pattern: break, then a make of zeros.

Decomposition:
- Shared package filter_pkg:
  - state enum
  - FRAME_BITS=8
  - relay width constant 7
- One sub-module, relay_shifter: loads an 8-bit word on start, generates sr_clk/sr_data/sr_latch per CLK_DIV, and pulses done.
- The parent FSM invokes relay_shifter twice per switch.

Test Plan:
- Power-up, CLK_DIV=2, STABLE=16, BREAK=32, SETTLE=64; selected_filter=7'b0001000 held after reset release.
  - Expect QUALIFY for 16 cycles, then a zero frame (36 cycles), then 32 idle cycles.
  - Then frame 8'b00001000 with 8 sr_clk rising edges and one latch pulse; filter_active=7'b0001000 at latch.
  - tx_inhibit low 64 cycles after the make frame ends.
- Request flicker: 7'b0000100 for 10 cycles, then back to 7'b0001000 (already active).
  - Expect return to IDLE, no sr_clk activity, busy never high.
- Deferral: ptt=1, change to 7'b0100010 and hold for 100 cycles.
  - No shift may occur.
  - ptt falls: SHIFT_BREAK starts on the next cycle and the sequence completes with filter_active=7'b0100010.
- ptt rises during WAIT_BREAK: the sequence finishes, tx_inhibit stays 1 until settle completes, and filter_active is updated.
- selected_filter changes to 7'b1000000 during SHIFT_MAKE of 7'b0010010.
  - filter_active=7'b0010010 first.
  - Then, after IDLE, a full re-qualify and second switch to 7'b1000000.
- reset_n asserted mid SHIFT_MAKE: all outputs go to 0 asynchronously (before the next clock edge).
  - After release with the request unchanged, a full qualify, break and make sequence repeats.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the filter relay driver.
// Holds the FSM state encoding, the serial frame width and the relay width,
// plus a small constant helper used to size the shared dwell counter.
package filter_pkg;

  localparam int FRAME_BITS = 8;
  localparam int RELAY_BITS = 7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_QUALIFY     = 3'd1;
  localparam state_t ST_SHIFT_BREAK = 3'd2;
  localparam state_t ST_WAIT_BREAK  = 3'd3;
  localparam state_t ST_SHIFT_MAKE  = 3'd4;
  localparam state_t ST_WAIT_SETTLE = 3'd5;

  // Largest of three dwell lengths; sizes the one counter shared by all dwells.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/relay_shifter.sv
// Serialises one 8-bit frame into a 74HC595-class shift/storage register.
// Per bit: sr_clk high for CLK_DIV cycles, then low for CLK_DIV cycles, MSB
// first; after bit 0 sr_latch is high for CLK_DIV cycles then low for CLK_DIV.
// A frame occupies exactly 18*CLK_DIV cycles starting on the start edge.
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   start, word      begin a frame with this word (ignored while a frame runs)
//   sr_clk/sr_data/sr_latch  serial interface to the relay driver
//   latch_set        high on the cycle whose edge raises sr_latch
//   done             high on the last cycle of the frame
module relay_shifter
  import filter_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  sr_clk,
  output logic                  sr_data,
  output logic                  sr_latch,
  output logic                  latch_set,
  output logic                  done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  // Half-periods 0..15 carry the 8 bits, 16 is latch high, 17 is latch low.
  localparam logic [4:0] HALF_LATCH_PRE = 5'd15;
  localparam logic [4:0] HALF_LATCH_HI  = 5'd16;
  localparam logic [4:0] HALF_LAST      = 5'd17;

  logic                  active_r;
  logic [DW-1:0]         div_r;
  logic [4:0]            half_r;
  logic [FRAME_BITS-1:0] word_r;
  logic                  half_end_s;

  // Half-period boundary and the strobes the parent FSM sequences on.
  always_comb begin
    half_end_s = active_r && (div_r == DIV_LAST);
    latch_set  = half_end_s && (half_r == HALF_LATCH_PRE);
    done       = half_end_s && (half_r == HALF_LAST);
  end

  // Frame sequencer: divider, half-period index and serial output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_r <= 1'b0;
      div_r    <= '0;
      half_r   <= 5'd0;
      word_r   <= '0;
      sr_clk   <= 1'b0;
      sr_data  <= 1'b0;
      sr_latch <= 1'b0;
    end else if (!active_r) begin
      if (start) begin
        // The frame MSB is always 0 and sr_data idles at 0, so the first
        // sr_clk rise never sees the data line move.
        active_r <= 1'b1;
        div_r    <= '0;
        half_r   <= 5'd0;
        sr_clk   <= 1'b1;
        sr_data  <= word[FRAME_BITS-1];
        word_r   <= {word[FRAME_BITS-2:0], 1'b0};
      end
    end else if (half_end_s) begin
      div_r <= '0;
      if (half_r == HALF_LAST) begin
        active_r <= 1'b0;
      end else begin
        half_r <= half_r + 5'd1;
        case (half_r)
          HALF_LATCH_PRE: sr_latch <= 1'b1;
          HALF_LATCH_HI:  sr_latch <= 1'b0;
          default: begin
            if (half_r[0]) begin
              sr_clk <= 1'b1;
            end else begin
              // Falling edge: present the next bit while sr_clk is low.
              sr_clk  <= 1'b0;
              sr_data <= word_r[FRAME_BITS-1];
              word_r  <= {word_r[FRAME_BITS-2:0], 1'b0};
            end
          end
        endcase
      end
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

endmodule

// File: rtl/filter_relay_driver.sv
// Band-filter relay driver. Qualifies a change of the requested relay pattern,
// defers it while transmitting, then performs break-before-make: an all-zero
// frame, a break dwell, the target frame, and a settle dwell. TX is inhibited
// from the start of the break frame to the end of settle.
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   selected_filter  requested relay pattern (registered upstream)
//   ptt              transmit active; blocks the start of a switch
//   sr_clk/sr_data/sr_latch  serial interface to the relay driver
//   filter_active    pattern last latched into the relays
//   busy, tx_inhibit high while a switch sequence is in progress
module filter_relay_driver
  import filter_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int STABLE_CYCLES = 1024,
  parameter int BREAK_CYCLES  = 2048,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [RELAY_BITS-1:0] selected_filter,
  input  logic                  ptt,
  output logic                  sr_clk,
  output logic                  sr_data,
  output logic                  sr_latch,
  output logic [RELAY_BITS-1:0] filter_active,
  output logic                  busy,
  output logic                  tx_inhibit
);

  localparam int CW = $clog2(max3(STABLE_CYCLES, BREAK_CYCLES, SETTLE_CYCLES)) + 1;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] BREAK_C  = CW'(BREAK_CYCLES);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t                  state_r;
  logic [RELAY_BITS-1:0]   target_r;
  logic [CW-1:0]           cnt_r;
  logic                    go_s;
  logic                    make_go_s;
  logic                    start_s;
  logic [FRAME_BITS-1:0]   word_s;
  logic                    latch_set_s;
  logic                    done_s;

  // Frame launch decisions; both frames are started on the edge that
  // enters the corresponding shift state.
  always_comb begin
    go_s      = (state_r == ST_QUALIFY) && (selected_filter != filter_active) &&
                (selected_filter == target_r) && (cnt_r == STABLE_C) && !ptt;
    make_go_s = (state_r == ST_WAIT_BREAK) && (cnt_r == BREAK_C);
    start_s   = go_s || make_go_s;
    if (go_s) begin
      word_s = '0;
    end else begin
      word_s = {1'b0, target_r};
    end
  end

  relay_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start_s),
    .word      (word_s),
    .sr_clk    (sr_clk),
    .sr_data   (sr_data),
    .sr_latch  (sr_latch),
    .latch_set (latch_set_s),
    .done      (done_s)
  );

  // Switch sequencing FSM with one dwell counter reused by every wait state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      target_r      <= '0;
      cnt_r         <= '0;
      filter_active <= '0;
      busy          <= 1'b0;
      tx_inhibit    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (selected_filter != filter_active) begin
            state_r  <= ST_QUALIFY;
            target_r <= selected_filter;
            cnt_r    <= CNT_ONE;
          end
        end
        ST_QUALIFY: begin
          if (selected_filter == filter_active) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end else if (selected_filter != target_r) begin
            target_r <= selected_filter;
            cnt_r    <= CNT_ONE;
          end else if (go_s) begin
            state_r    <= ST_SHIFT_BREAK;
            cnt_r      <= '0;
            busy       <= 1'b1;
            tx_inhibit <= 1'b1;
          end else if (cnt_r != STABLE_C) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
          // At the terminal count with ptt high the counter simply holds.
        end
        ST_SHIFT_BREAK: begin
          if (done_s) begin
            state_r <= ST_WAIT_BREAK;
            cnt_r   <= CNT_ONE;
          end
        end
        ST_WAIT_BREAK: begin
          if (make_go_s) begin
            state_r <= ST_SHIFT_MAKE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SHIFT_MAKE: begin
          if (latch_set_s) begin
            filter_active <= target_r;
          end
          if (done_s) begin
            state_r <= ST_WAIT_SETTLE;
            cnt_r   <= CNT_ONE;
          end
        end
        ST_WAIT_SETTLE: begin
          if (cnt_r == SETTLE_C) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            busy       <= 1'b0;
            tx_inhibit <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= '0;
          busy       <= 1'b0;
          tx_inhibit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_relay_driver.sv
// Self-checking bench for filter_relay_driver. A timeline model predicts when
// a switch starts (request stable for STABLE_CYCLES+1 consecutive samples with
// ptt low) and derives every later event from the sequence age. A virtual
// 74HC595 rebuilds each latched frame from the serial pins.
module tb_filter_relay_driver;

  localparam int D = 2;
  localparam int S = 16;
  localparam int B = 32;
  localparam int T = 64;
  localparam int L = 36 * D + B + T;
  localparam int AGE_BREAK_LATCH = 16 * D;
  localparam int AGE_MAKE_START  = 18 * D + B;
  localparam int AGE_MAKE_LATCH  = 34 * D + B;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] selected_filter = 7'd0;
  logic       ptt = 1'b0;
  logic       sr_clk, sr_data, sr_latch, busy, tx_inhibit;
  logic [6:0] filter_active;

  int total = 0;
  int bad = 0;

  // Reference model state.
  logic [6:0] exp_fa = 7'd0;
  logic       in_seq = 1'b0;
  int         age = 0;
  int         run = 0;
  logic [6:0] run_val = 7'd0;
  logic [6:0] seq_target = 7'd0;

  // Virtual shift/storage register.
  logic [7:0] shreg = 8'd0;
  int         nrise = 0;
  logic       prev_clk = 1'b0;
  logic       prev_latch = 1'b0;

  always #5 clock = ~clock;

  filter_relay_driver #(
    .CLK_DIV       (D),
    .STABLE_CYCLES (S),
    .BREAK_CYCLES  (B),
    .SETTLE_CYCLES (T)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .selected_filter (selected_filter),
    .ptt             (ptt),
    .sr_clk          (sr_clk),
    .sr_data         (sr_data),
    .sr_latch        (sr_latch),
    .filter_active   (filter_active),
    .busy            (busy),
    .tx_inhibit      (tx_inhibit)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (!reset_n) begin
      exp_fa = 7'd0; in_seq = 1'b0; age = 0; run = 0; run_val = 7'd0; seq_target = 7'd0;
    end else if (in_seq) begin
      age++;
      if (age == AGE_MAKE_LATCH) exp_fa = seq_target;
      if (age == L) in_seq = 1'b0;
    end else if (selected_filter == exp_fa) begin
      run = 0;
    end else begin
      if (run > 0 && selected_filter == run_val) begin
        run++;
      end else begin
        run = 1;
        run_val = selected_filter;
      end
      if (run >= S + 1 && !ptt) begin
        in_seq = 1'b1; age = 0; seq_target = selected_filter; run = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("filter_active", filter_active, exp_fa);
    check_eq("busy", busy, in_seq);
    check_eq("tx_inhibit", tx_inhibit, in_seq);
    if (!in_seq) begin
      check_eq("quiet_sr_clk", sr_clk, 1'b0);
      check_eq("quiet_sr_latch", sr_latch, 1'b0);
    end
    if (!reset_n) begin
      shreg = 8'd0; nrise = 0;
    end else begin
      if (sr_clk && !prev_clk) begin
        shreg = {shreg[6:0], sr_data};
        nrise++;
      end
      if (sr_latch && !prev_latch) begin
        check_eq("clk_rises_per_frame", nrise, 8);
        check_eq("latch_age", age, (age < AGE_MAKE_START) ? AGE_BREAK_LATCH : AGE_MAKE_LATCH);
        check_eq("latched_frame", shreg, (age < AGE_MAKE_START) ? 8'h00 : {1'b0, seq_target});
        nrise = 0;
      end
    end
    prev_clk = sr_clk;
    prev_latch = sr_latch;
  endtask

  task automatic cycle(input logic [6:0] s, input logic p);
    @(negedge clock);
    selected_filter = s;
    ptt = p;
    @(posedge clock);
    #1;
    model_edge();
    check_outputs();
  endtask

  task automatic hold(input logic [6:0] s, input logic p, input int n);
    for (int i = 0; i < n; i++) cycle(s, p);
  endtask

  task automatic run_to_age(input logic [6:0] s, input logic p, input int target_age, input int budget);
    int   n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      cycle(s, p);
      n++;
      hit = in_seq && (age == target_age);
    end
    check_eq("reach_sequence_age", hit, 1'b1);
  endtask

  initial begin
    logic [6:0] s;
    logic       p;
    int         n;

    // Power-up: request held through reset, full qualify/break/make/settle.
    hold(7'b0001000, 1'b0, 4);
    reset_n = 1'b1;
    hold(7'b0001000, 1'b0, S + 1 + L + 5);
    check_eq("powerup_filter", filter_active, 7'b0001000);

    // Flicker back to the active pattern: no switch may happen.
    hold(7'b0000100, 1'b0, 10);
    hold(7'b0001000, 1'b0, 30);

    // Deferral while transmitting, then immediate start once ptt drops.
    hold(7'b0100010, 1'b1, 100);
    hold(7'b0100010, 1'b0, 1);
    check_eq("defer_start", tx_inhibit, 1'b1);
    hold(7'b0100010, 1'b0, L + 5);
    check_eq("defer_filter", filter_active, 7'b0100010);

    // ptt rises during the break dwell; sequence still completes.
    run_to_age(7'b0000001, 1'b0, 18 * D + 5, 300);
    hold(7'b0000001, 1'b1, L);
    check_eq("ptt_mid_filter", filter_active, 7'b0000001);
    hold(7'b0000001, 1'b0, 5);

    // Request changes during the make frame: first switch, then a second.
    run_to_age(7'b0010010, 1'b0, AGE_MAKE_START + 5, 300);
    hold(7'b1000000, 1'b0, L);
    check_eq("first_switch", filter_active, 7'b0010010);
    hold(7'b1000000, 1'b0, L);
    check_eq("second_switch", filter_active, 7'b1000000);

    // Asynchronous reset during the make frame, then a full repeat.
    run_to_age(7'b0000110, 1'b0, AGE_MAKE_START + 10, 300);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_sr_clk", sr_clk, 1'b0);
    check_eq("async_sr_data", sr_data, 1'b0);
    check_eq("async_sr_latch", sr_latch, 1'b0);
    check_eq("async_filter", filter_active, 7'd0);
    check_eq("async_busy", busy, 1'b0);
    check_eq("async_tx_inhibit", tx_inhibit, 1'b0);
    hold(7'b0000110, 1'b0, 3);
    reset_n = 1'b1;
    hold(7'b0000110, 1'b0, S + 1 + L + 5);
    check_eq("post_reset_filter", filter_active, 7'b0000110);

    // Randomized requests, including all-zero and the active pattern, with
    // random ptt activity.
    p = 1'b0;
    for (int ph = 0; ph < 40; ph++) begin
      case ($urandom_range(0, 3))
        0: s = exp_fa;
        1: s = 7'd0;
        default: s = 7'($urandom);
      endcase
      n = ($urandom_range(0, 3) == 0) ? 200 : $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 15) == 0) p = ~p;
        cycle(s, p);
      end
    end
    hold(s, 1'b0, S + 1 + 2 * L + 10);
    check_eq("final_filter", filter_active, s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
